id_fetch_buffer: RTL and testbench



---
 rtl/id_fetch_buffer.sv | 123 ++++++++++++
 tb/tb_id_fetch_buffer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/id_fetch_buffer.sv
// rtl/id_fetch_buffer.sv - IF/ID instruction buffer pairing fetch PCs with late SRAM data
//
// Sits between IF and ID. Each accepted fetch becomes a pending entry whose
// instruction word arrives on inst_sram_rdata one cycle later. When the FIFO
// is empty that pending word is handed to ID combinationally (fall-through);
// otherwise it is appended behind the stored entries. A redirect flush drops
// everything except a fetch issued in the flush cycle itself.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             redirect; discard stored and pending entries
//   fetch_valid/pc    fetch issued by IF this cycle
//   inst_sram_rdata   instruction for the fetch issued the previous cycle
//   fetch_ready       IF may issue a fetch this cycle
//   id_valid/pc/inst  head entry presented to ID (pc/inst are 0 when invalid)
//   id_ready          ID consumes the head this cycle
//   count             number of stored FIFO entries
module id_fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              fetch_ready,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  output logic [CNT_W-1:0]  count
);

  logic [PC_W-1:0]   r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_pend_v;
  logic [PC_W-1:0]   r_pend_pc;

  logic              w_head_stored;
  logic              w_head_fall;
  logic              w_pop;
  logic              w_pop_stored;
  logic              w_push;
  logic              w_accept;
  logic [CNT_W:0]    w_occupancy;

  assign w_head_stored = (r_count != '0);
  assign w_head_fall   = ~w_head_stored & r_pend_v;

  assign w_pop        = id_valid & id_ready & ~flush;
  assign w_pop_stored = w_pop & w_head_stored;
  // A pending word consumed straight through by ID never enters the FIFO.
  assign w_push       = r_pend_v & ~flush & ~(w_pop & w_head_fall);

  // Conservative: an in-flight word always needs a slot, and a same-cycle pop
  // is not credited, so the FIFO can never be written while full.
  assign w_occupancy = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pend_v};
  assign fetch_ready = flush | (w_occupancy < (CNT_W + 1)'(DEPTH));
  assign w_accept    = fetch_valid & fetch_ready;

  assign count = r_count;

  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    if (w_head_stored) begin
      id_valid = 1'b1;
      id_pc    = r_pc_mem[r_rd_ptr];
      id_inst  = r_inst_mem[r_rd_ptr];
    end else if (r_pend_v) begin
      id_valid = 1'b1;
      id_pc    = r_pend_pc;
      id_inst  = inst_sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
    end else begin
      // The redirect target fetched during a flush survives as the new pending word.
      r_pend_v <= w_accept;
      if (w_accept) begin
        r_pend_pc <= fetch_pc;
      end
      if (flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop_stored) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop_stored);
      end
    end
  end

  // Storage needs no reset; count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_pend_pc;
      r_inst_mem[r_wr_ptr] <= inst_sram_rdata;
    end
  end

endmodule

// File: tb/tb_id_fetch_buffer.sv
// tb/tb_id_fetch_buffer.sv - directed self-checking bench for id_fetch_buffer
module tb_id_fetch_buffer;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] inst_sram_rdata;
  logic        id_ready;

  logic        fr1, iv1, fr2, iv2;
  logic [31:0] ipc1, iinst1, ipc2, iinst2;
  logic [2:0]  cnt1;
  logic [1:0]  cnt2;

  logic        sel;
  logic        s_fr, s_iv;
  logic [31:0] s_pc, s_inst;
  logic [2:0]  s_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_fetch_buffer #(.DEPTH(4), .PC_W(32), .INST_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .inst_sram_rdata(inst_sram_rdata), .fetch_ready(fr1),
    .id_valid(iv1), .id_pc(ipc1), .id_inst(iinst1), .id_ready(id_ready), .count(cnt1)
  );

  id_fetch_buffer #(.DEPTH(2), .PC_W(32), .INST_W(32)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .inst_sram_rdata(inst_sram_rdata), .fetch_ready(fr2),
    .id_valid(iv2), .id_pc(ipc2), .id_inst(iinst2), .id_ready(id_ready), .count(cnt2)
  );

  assign s_fr   = sel ? fr2 : fr1;
  assign s_iv   = sel ? iv2 : iv1;
  assign s_pc   = sel ? ipc2 : ipc1;
  assign s_inst = sel ? iinst2 : iinst1;
  assign s_cnt  = sel ? {1'b0, cnt2} : cnt1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction SRAM / IF model: rdata answers last cycle's address, PC advances on accept.
  task automatic adv();
    logic acc;
    acc = fetch_valid & s_fr;
    @(posedge clk);
    #1;
    inst_sram_rdata = inst_of(fetch_pc);
    if (acc) fetch_pc = fetch_pc + 32'd4;
  endtask

  task automatic row(input string sc, input logic fv, input logic rdy, input logic fl,
                     input logic efr, input int ecnt, input logic eiv, input logic [31:0] epc);
    fetch_valid = fv;
    id_ready    = rdy;
    flush       = fl;
    @(negedge clk);
    check({sc, "_fetch_ready"}, 64'(s_fr), 64'(efr));
    check({sc, "_count"}, 64'(s_cnt), 64'(ecnt));
    check({sc, "_id_valid"}, 64'(s_iv), 64'(eiv));
    check({sc, "_id_pc"}, 64'(s_pc), eiv ? 64'(epc) : 64'd0);
    check({sc, "_id_inst"}, 64'(s_inst), eiv ? 64'(inst_of(epc)) : 64'd0);
    adv();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_valid = 1'b0;
    id_ready = 1'b0;
    flush = 1'b0;
    fetch_pc = BASE;
    inst_sram_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && cnt1 == 3'd4) check("no_push_full_d4", 64'(u_dut.w_push), 64'd0);
    if (rst_n === 1'b1 && cnt2 == 2'd2) check("no_push_full_d2", 64'(u_dut2.w_push), 64'd0);
  end

  int pat [16] = '{0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0};

  initial begin
    logic [31:0] exp_next;
    int hits;
    sel = 1'b0;
    rst_n = 1'b1;
    flush = 1'b0;
    fetch_valid = 1'b0;
    id_ready = 1'b0;
    fetch_pc = BASE;
    inst_sram_rdata = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_id_valid", 64'(iv1), 64'd0);
    check("rst_fetch_ready", 64'(fr1), 64'd1);
    check("rst_count", 64'(cnt1), 64'd0);
    do_reset();

    // Reset asserted mid-stall with three entries held.
    row("s1", 1, 0, 0, 1, 0, 0, 32'd0);
    row("s1", 1, 0, 0, 1, 0, 1, BASE);
    row("s1", 1, 0, 0, 1, 1, 1, BASE);
    row("s1", 0, 0, 0, 1, 2, 1, BASE);
    row("s1", 0, 0, 0, 1, 3, 1, BASE);
    #2 rst_n = 1'b0;
    #1;
    check("s1_async_id_valid", 64'(iv1), 64'd0);
    check("s1_async_id_pc", 64'(ipc1), 64'd0);
    check("s1_async_id_inst", 64'(iinst1), 64'd0);
    check("s1_async_fetch_ready", 64'(fr1), 64'd1);
    check("s1_async_count", 64'(cnt1), 64'd0);
    do_reset();

    // Streaming with ID always ready: zero added latency, nothing stored.
    row("s2", 1, 1, 0, 1, 0, 0, 32'd0);
    for (int k = 1; k <= 8; k++) row("s2", 1, 1, 0, 1, 0, 1, BASE + 32'(4 * (k - 1)));
    row("s2", 0, 1, 0, 1, 0, 1, BASE + 32'd32);
    row("s2", 0, 1, 0, 1, 0, 0, 32'd0);

    // Stall then drain, DEPTH 4.
    do_reset();
    row("s3", 1, 0, 0, 1, 0, 0, 32'd0);
    row("s3", 1, 0, 0, 1, 0, 1, BASE);
    row("s3", 1, 0, 0, 1, 1, 1, BASE);
    row("s3", 1, 0, 0, 1, 2, 1, BASE);
    row("s3", 1, 0, 0, 0, 3, 1, BASE);
    row("s3", 1, 0, 0, 0, 4, 1, BASE);
    row("s3", 0, 1, 0, 0, 4, 1, BASE);
    row("s3", 0, 1, 0, 1, 3, 1, BASE + 32'h4);
    row("s3", 0, 1, 0, 1, 2, 1, BASE + 32'h8);
    row("s3", 0, 1, 0, 1, 1, 1, BASE + 32'hC);
    row("s3", 1, 1, 0, 1, 0, 0, 32'd0);
    row("s3", 1, 1, 0, 1, 0, 1, BASE + 32'h10);
    row("s3", 0, 1, 0, 1, 0, 1, BASE + 32'h14);
    row("s3", 0, 1, 0, 1, 0, 0, 32'd0);

    // Flush with three stored plus one pending; redirect target fetched in flush cycle.
    do_reset();
    row("s4", 1, 0, 0, 1, 0, 0, 32'd0);
    row("s4", 1, 0, 0, 1, 0, 1, BASE);
    row("s4", 1, 0, 0, 1, 1, 1, BASE);
    row("s4", 1, 0, 0, 1, 2, 1, BASE);
    fetch_pc = BASE + 32'h100;
    row("s4", 1, 1, 1, 1, 3, 1, BASE);
    row("s4", 0, 1, 0, 1, 0, 1, BASE + 32'h100);
    row("s4", 0, 1, 0, 1, 0, 0, 32'd0);
    row("s4", 1, 0, 0, 1, 0, 0, 32'd0);
    row("s4", 0, 0, 1, 1, 0, 1, BASE + 32'h104);
    row("s4", 0, 1, 0, 1, 0, 0, 32'd0);

    // Wrap-around: 12 fetches, irregular id_ready, in-order check.
    do_reset();
    exp_next = BASE;
    hits = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      fetch_valid = (fetch_pc != BASE + 32'd48);
      id_ready = (cyc < 16) ? pat[cyc][0] : 1'b1;
      flush = 1'b0;
      @(negedge clk);
      check("s5_count_max", 64'(cnt1 <= 3'd4), 64'd1);
      if (cnt1 == 3'd3 && !fr1 && id_ready) hits++;
      if (iv1 && id_ready) begin
        check("s5_id_pc", 64'(ipc1), 64'(exp_next));
        check("s5_id_inst", 64'(iinst1), 64'(inst_of(exp_next)));
        exp_next = exp_next + 32'd4;
      end
      adv();
    end
    check("s5_all_delivered", 64'(exp_next), 64'(BASE + 32'd48));
    check("s5_push_pop_at_3", 64'(hits > 0), 64'd1);

    // Stall then drain, DEPTH 2.
    sel = 1'b1;
    do_reset();
    row("s6", 1, 0, 0, 1, 0, 0, 32'd0);
    row("s6", 1, 0, 0, 1, 0, 1, BASE);
    row("s6", 1, 0, 0, 0, 1, 1, BASE);
    row("s6", 1, 0, 0, 0, 2, 1, BASE);
    row("s6", 1, 0, 0, 0, 2, 1, BASE);
    row("s6", 1, 0, 0, 0, 2, 1, BASE);
    row("s6", 0, 1, 0, 0, 2, 1, BASE);
    row("s6", 0, 1, 0, 1, 1, 1, BASE + 32'h4);
    row("s6", 1, 1, 0, 1, 0, 0, 32'd0);
    row("s6", 0, 1, 0, 1, 0, 1, BASE + 32'h8);
    row("s6", 0, 1, 0, 1, 0, 0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
